tree_result_collector: RTL and testbench



---
 rtl/tree_result_collector_pkg.sv | 26 ++
 rtl/tree_result_collector_if.sv | 26 ++
 rtl/tree_result_collector_result_fifo.sv | 51 +++++
 rtl/tree_result_collector.sv | 122 ++++++++++++
 tb/tb_tree_result_collector.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/tree_result_collector_pkg.sv
// Shared sizing helpers and types for the adder-tree result collector.
package tree_result_collector_pkg;

  // Result width of an N-input adder tree built from DATA_WIDTH-bit elements.
  function automatic int unsigned tree_width(input int unsigned n, input int unsigned dw);
    int unsigned lg;
    int unsigned extra;
    lg    = $clog2(n);
    extra = ((n - 1) >= (32'd1 << lg)) ? 1 : 0;
    return dw + lg + extra;
  endfunction

  // Pipeline depth of the tree; never less than one register stage.
  function automatic int unsigned tree_latency(input int unsigned n);
    int unsigned lg;
    lg = $clog2(n);
    return (lg < 1) ? 1 : lg;
  endfunction

  // Issue-side tag that travels alongside the tree data.
  typedef struct packed {
    logic valid;
    logic last;
  } beat_tag_t;

endpackage

// File: rtl/tree_result_collector_if.sv
// Handshake bundle between the tree/upstream/consumer side and the collector.
interface tree_result_collector_if
  import tree_result_collector_pkg::*;
#(
  parameter int unsigned TREE_WIDTH = tree_width(32, 33),
  parameter int unsigned ACC_WIDTH  = TREE_WIDTH + $clog2(16)
);
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;
  logic [TREE_WIDTH-1:0] tree_result;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_WIDTH-1:0]  out_data;
  logic                  chunk_err;

  modport master (
    output in_valid, in_last, tree_result, out_ready,
    input  in_ready, out_valid, out_data, chunk_err
  );

  modport slave (
    input  in_valid, in_last, tree_result, out_ready,
    output in_ready, out_valid, out_data, chunk_err
  );
endinterface

// File: rtl/tree_result_collector_result_fifo.sv
// Show-ahead synchronous FIFO for completed sums; head is always on o_head.
module result_fifo #(
  parameter int unsigned WIDTH = 42,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (ADDR_W+1)'(DEPTH));
  assign o_head    = r_mem[r_rptr];
  // A pop frees the slot in the same cycle, so push-while-full is fine with a pop.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage, wrapping pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_push_data;
        r_wptr        <= r_wptr + ADDR_W'(1);
      end
      if (w_do_pop) r_rptr <= r_rptr + ADDR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/tree_result_collector.sv
// Consumer end of the pipelined adder tree: aligns issue tags with tree output,
// accumulates multi-chunk sums, buffers results and throttles issue by credits.
module tree_result_collector
  import tree_result_collector_pkg::*;
#(
  parameter int unsigned N          = 32,
  parameter int unsigned DATA_WIDTH = 33,
  parameter int unsigned TREE_WIDTH = tree_width(N, DATA_WIDTH),
  parameter int unsigned LATENCY    = tree_latency(N),
  parameter int unsigned MAX_CHUNKS = 16,
  parameter int unsigned ACC_WIDTH  = TREE_WIDTH + $clog2(MAX_CHUNKS),
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  tree_result_collector_if.slave  bus
);
  localparam int unsigned CNT_W  = (MAX_CHUNKS > 1) ? $clog2(MAX_CHUNKS) : 1;
  localparam int unsigned CRED_W = $clog2(FIFO_DEPTH + 1);

  beat_tag_t                    r_pipe [LATENCY];
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic                         r_first;
  logic [CNT_W-1:0]             r_chunk_cnt;
  logic                         r_chunk_err;
  logic [CRED_W-1:0]            r_credits;

  logic                         w_accept;
  logic                         w_reserve;
  logic                         w_pop;
  logic                         w_push;
  logic                         w_dv;
  logic                         w_dl;
  logic                         w_fifo_full;
  logic                         w_fifo_empty;
  logic signed [ACC_WIDTH-1:0]  w_tree_ext;
  logic signed [ACC_WIDTH-1:0]  w_acc_next;

  // Beats offered without a credit are dropped so they never reach the FIFO.
  assign bus.in_ready  = (r_credits != '0);
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign w_reserve     = w_accept && bus.in_last;
  assign bus.out_valid = !w_fifo_empty;
  assign w_pop         = bus.out_valid && bus.out_ready;
  assign bus.chunk_err = r_chunk_err;

  assign w_dv       = r_pipe[LATENCY-1].valid;
  assign w_dl       = r_pipe[LATENCY-1].last;
  assign w_tree_ext = ACC_WIDTH'($signed(bus.tree_result));
  assign w_acc_next = (r_first ? '0 : r_acc) + w_tree_ext;
  assign w_push     = w_dv && w_dl;

  // Delay accepted {valid,last} by the tree latency so they line up with tree_result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LATENCY; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= '{valid: w_accept, last: w_accept && bus.in_last};
      for (int unsigned i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  // Running sum across chunks; a delayed last restarts the next sum from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_first <= 1'b1;
    end else if (w_dv) begin
      r_acc   <= w_acc_next;
      r_first <= w_dl;
    end
  end

  // Chunks-per-sum counter with a sticky overflow flag; counting wraps after overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chunk_cnt <= '0;
      r_chunk_err <= 1'b0;
    end else if (w_dv) begin
      if (w_dl) begin
        r_chunk_cnt <= '0;
      end else if (r_chunk_cnt == CNT_W'(MAX_CHUNKS - 1)) begin
        r_chunk_cnt <= '0;
        r_chunk_err <= 1'b1;
      end else begin
        r_chunk_cnt <= r_chunk_cnt + CNT_W'(1);
      end
    end
  end

  // One credit per FIFO slot: reserved at issue of a last beat, returned on pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credits <= CRED_W'(FIFO_DEPTH);
    end else begin
      case ({w_reserve, w_pop})
        2'b10:   r_credits <= r_credits - CRED_W'(1);
        2'b01:   r_credits <= r_credits + CRED_W'(1);
        default: r_credits <= r_credits;
      endcase
    end
  end

  // Credit accounting must make a push into a full, non-popping FIFO impossible.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) assert (!w_fifo_full || w_pop);
  end

  result_fifo #(
    .WIDTH (ACC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_acc_next),
    .i_pop       (w_pop),
    .o_head      (bus.out_data),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );
endmodule

// File: tb/tb_tree_result_collector.sv
// Directed bench for tree_result_collector (N=4, LATENCY=2, FIFO_DEPTH=2, MAX_CHUNKS=4).
module tb_tree_result_collector;
  localparam int unsigned TW = 35;
  localparam int unsigned AW = 37;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic [AW-1:0] e_all_ones;

  always #5 clk = ~clk;

  tree_result_collector_if #(.TREE_WIDTH(TW), .ACC_WIDTH(AW)) bus ();

  tree_result_collector #(
    .N          (4),
    .DATA_WIDTH (33),
    .MAX_CHUNKS (4),
    .FIFO_DEPTH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic l, input logic [TW-1:0] tr);
    bus.in_valid    = v;
    bus.in_last     = l;
    bus.tree_result = tr;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    e_all_ones = '1;
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 1'b0, '0);
    tick(); tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready",  bus.in_ready,  1);
    chk("rst_out_data",  bus.out_data,  0);
    chk("rst_chunk_err", bus.chunk_err, 0);
    rst_n = 1'b1;
    tick();

    // Single chunk: issue at c0, tree=10 at c2, result at c3.
    drive(1'b1, 1'b1, TW'(999)); tick();
    drive(1'b0, 1'b0, TW'(888)); tick();
    chk("single_early", bus.out_valid, 0);
    drive(1'b0, 1'b0, TW'(10)); tick();
    chk("single_valid", bus.out_valid, 1);
    chk("single_data",  bus.out_data,  AW'(10));
    bus.out_ready = 1'b1;
    drive(1'b0, 1'b0, TW'(555)); tick();
    chk("single_drained", bus.out_valid, 0);
    bus.out_ready = 1'b0;

    // Three chunks: 5 + (-3) + 100 = 102 at c5, one result only.
    drive(1'b1, 1'b0, TW'(777)); tick();
    drive(1'b1, 1'b0, TW'(666)); tick();
    drive(1'b1, 1'b1, TW'(5));   tick();
    drive(1'b0, 1'b0, TW'(-3));  tick();
    chk("multi_early", bus.out_valid, 0);
    drive(1'b0, 1'b0, TW'(100)); tick();
    chk("multi_valid", bus.out_valid, 1);
    chk("multi_data",  bus.out_data,  AW'(102));
    bus.out_ready = 1'b1;
    drive(1'b0, 1'b0, TW'(444)); tick();
    chk("multi_single_result", bus.out_valid, 0);
    bus.out_ready = 1'b0;

    // Backpressure: two sums fill the credits; an offer without credit is ignored.
    chk("bp_ready_c0", bus.in_ready, 1);
    drive(1'b1, 1'b1, TW'(999)); tick();
    chk("bp_ready_c1", bus.in_ready, 1);
    drive(1'b1, 1'b1, TW'(888)); tick();
    chk("bp_ready_c2", bus.in_ready, 0);
    drive(1'b1, 1'b1, TW'(11));  tick();
    chk("bp_ready_c3", bus.in_ready, 0);
    chk("bp_valid_c3", bus.out_valid, 1);
    chk("bp_data_c3",  bus.out_data, AW'(11));
    drive(1'b0, 1'b0, TW'(22));  tick();
    chk("bp_ready_c4", bus.in_ready, 0);
    chk("bp_data_c4",  bus.out_data, AW'(11));
    bus.out_ready = 1'b1;
    drive(1'b0, 1'b0, TW'(33));  tick();
    chk("bp_ready_after_pop", bus.in_ready, 1);
    chk("bp_valid_second",    bus.out_valid, 1);
    chk("bp_data_second",     bus.out_data, AW'(22));
    drive(1'b0, 1'b0, TW'(0));   tick();
    chk("bp_ignored_offer", bus.out_valid, 0);
    bus.out_ready = 1'b0;

    // Sign extension of an all-ones tree result.
    drive(1'b1, 1'b1, TW'(0)); tick();
    drive(1'b0, 1'b0, TW'(0)); tick();
    drive(1'b0, 1'b0, '1);     tick();
    chk("sext_valid", bus.out_valid, 1);
    chk("sext_data",  bus.out_data,  e_all_ones);
    bus.out_ready = 1'b1;
    drive(1'b0, 1'b0, TW'(0)); tick();
    bus.out_ready = 1'b0;

    // Reset mid-operation discards in-flight beats.
    drive(1'b1, 1'b0, TW'(111)); tick();
    rst_n = 1'b0;
    drive(1'b1, 1'b0, TW'(222));
    #1;
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_ready", bus.in_ready,  1);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, TW'(333 + k));
      tick();
      chk("midrst_quiet_valid", bus.out_valid, 0);
      chk("midrst_quiet_ready", bus.in_ready,  1);
    end
    drive(1'b1, 1'b1, TW'(0)); tick();
    drive(1'b0, 1'b0, TW'(0)); tick();
    drive(1'b0, 1'b0, TW'(7)); tick();
    chk("midrst_sum_valid", bus.out_valid, 1);
    chk("midrst_sum_data",  bus.out_data,  AW'(7));
    bus.out_ready = 1'b1;
    drive(1'b0, 1'b0, TW'(0)); tick();
    bus.out_ready = 1'b0;

    // Chunk overflow: five non-last beats; 4th delayed beat is at c5, flag from c6.
    for (int k = 0; k < 10; k++) begin
      chk("chunk_err_seq", bus.chunk_err, (k >= 6) ? 1 : 0);
      drive(k < 5, 1'b0, (k >= 2 && k < 7) ? TW'(1) : TW'(0));
      tick();
    end
    chk("chunk_no_result", bus.out_valid, 0);
    rst_n = 1'b0;
    #1;
    chk("chunk_err_cleared", bus.chunk_err, 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
